ascon_round_ctrl: RTL and testbench

ASCON_ROUND_CTRL -- requirements
Module: ascon_round_ctrl

---
 rtl/ascon_round_ctrl.sv | 113 +++++++++++
 tb/tb_ascon_round_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ascon_round_ctrl.sv
// Ascon permutation round sequencer: counts rounds and cycles-per-round, and
// emits round constants plus constant-generator controls from registered state.
module ascon_round_ctrl #(
  parameter int CYC_PER_ROUND = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] nr,
  output logic       busy,
  output logic       done,
  output logic       cst_sel,
  output logic       cst_en,
  output logic [7:0] round_cst,
  output logic       round_first,
  output logic       round_last,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] PH_LAST  = 2'(CYC_PER_ROUND - 1);
  localparam logic [3:0] IDX_LAST = 4'd11;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] first_q, first_d;
  logic [1:0] phase_d;
  logic [3:0] nr_eff;

  logic       busy_d, done_d, cst_sel_d, cst_en_d;
  logic       round_first_d, round_last_d, run_d;
  logic [7:0] round_cst_d;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    first_d = first_q;
    phase_d = phase;
    nr_eff  = (nr == 4'd0 || nr > 4'd12) ? 4'd12 : nr;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 4'd12 - nr_eff;
          first_d = 4'd12 - nr_eff;
          phase_d = 2'd0;
        end
      end
      RUN: begin
        if (phase == PH_LAST) begin
          phase_d = 2'd0;
          if (idx_q == IDX_LAST) state_d = DONE;
          else                   idx_d   = idx_q + 4'd1;
        end else begin
          phase_d = phase + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next state so they land in registers with it.
    run_d         = (state_d == RUN);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    cst_en_d      = run_d && (phase_d == 2'd0);
    round_first_d = run_d && (idx_d == first_d);
    round_last_d  = run_d && (idx_d == IDX_LAST);
    cst_sel_d     = cst_en_d && round_first_d;
    round_cst_d   = run_d ? {4'hF - idx_d, idx_d} : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: only control state is reset; there is no storage array here, and
    // a reset first_q of 0 is the 12-round default.
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      first_q     <= 4'd0;
      phase       <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cst_sel     <= 1'b0;
      cst_en      <= 1'b0;
      round_cst   <= 8'h00;
      round_first <= 1'b0;
      round_last  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      phase       <= phase_d;
      busy        <= busy_d;
      done        <= done_d;
      cst_sel     <= cst_sel_d;
      cst_en      <= cst_en_d;
      round_cst   <= round_cst_d;
      round_first <= round_first_d;
      round_last  <= round_last_d;
    end
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Bench for ascon_round_ctrl: per-cycle output traces compared against a
// reference trace built from round count, cycles per round and constant rule.
module tb_ascon_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [3:0] nr, nr1;
  logic       busy, done, cst_sel, cst_en, round_first, round_last;
  logic [7:0] round_cst;
  logic [1:0] phase;
  logic       busy1, done1, cst_sel1, cst_en1, round_first1, round_last1;
  logic [7:0] round_cst1;
  logic [1:0] phase1;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ascon_round_ctrl #(.CYC_PER_ROUND(3)) dut (
    .clk(clk), .rst(rst), .start(start), .nr(nr),
    .busy(busy), .done(done), .cst_sel(cst_sel), .cst_en(cst_en),
    .round_cst(round_cst), .round_first(round_first),
    .round_last(round_last), .phase(phase)
  );

  ascon_round_ctrl #(.CYC_PER_ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .nr(nr1),
    .busy(busy1), .done(done1), .cst_sel(cst_sel1), .cst_en(cst_en1),
    .round_cst(round_cst1), .round_first(round_first1),
    .round_last(round_last1), .phase(phase1)
  );

  // Packed view: {busy, done, cst_sel, cst_en, round_cst, first, last, phase}
  function automatic logic [15:0] obs3();
    return {busy, done, cst_sel, cst_en, round_cst, round_first, round_last, phase};
  endfunction

  function automatic logic [15:0] obs1();
    return {busy1, done1, cst_sel1, cst_en1, round_cst1, round_first1, round_last1, phase1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected trace from the cycle after start is accepted: all RUN cycles,
  // the DONE cycle, then one IDLE cycle.
  task automatic build_trace(input int nr_in, input int cpr);
    int ne;
    int k;
    logic [7:0] cst;
    exp_q.delete();
    ne = (nr_in == 0 || nr_in > 12) ? 12 : nr_in;
    for (int r = 0; r < ne; r++) begin
      k   = 12 - ne + r;
      cst = 8'(((15 - k) * 16) + k);
      for (int p = 0; p < cpr; p++)
        exp_q.push_back({1'b1, 1'b0, (p == 0 && r == 0), (p == 0), cst,
                         (r == 0), (r == ne - 1), 2'(p)});
    end
    exp_q.push_back({1'b1, 1'b1, 14'h0});
    exp_q.push_back(16'h0);
  endtask

  task automatic test_run(input string name, input int nr_in, input bit noise);
    logic [15:0] o;
    build_trace(nr_in, 3);
    start = 1'b1;
    nr    = 4'(nr_in);
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      o = obs3();
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL %s nr=%0d cycle=%0d got=%h want=%h", name, nr_in, i + 1, o, exp_q[i]);
      end
      start = (noise && i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      nr    = 4'($urandom);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; nr = 4'd0; start1 = 1'b0; nr1 = 4'd0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs3() !== 16'h0 || obs1() !== 16'h0) begin
        bad++;
        $display("FAIL reset_idle cycle=%0d got=%h/%h want=0000", i, obs3(), obs1());
      end
      tick();
    end
  endtask

  task automatic test_full_run();
    int done_at = 0;
    int cyc = 0;
    test_run("full_nr12", 12, 1'b0);
    // Independent latency check: done lands 37 cycles after the accepting edge.
    start = 1'b1; nr = 4'd12;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
    done_at = cyc;
    total++;
    if (done_at != 37) begin
      bad++;
      $display("FAIL done_latency got=%0d want=37", done_at);
    end
    tick(); tick();
  endtask

  task automatic test_nr_cases();
    test_run("nr6", 6, 1'b0);
    test_run("nr0", 0, 1'b1);
    test_run("nr15", 15, 1'b1);
    test_run("nr1", 1, 1'b0);
    for (int j = 0; j < 6; j++) test_run("rand", int'($urandom_range(0, 15)), 1'b1);
  endtask

  task automatic test_abort();
    logic [15:0] o;
    build_trace(12, 3);
    start = 1'b1; nr = 4'd12;
    tick();
    start = 1'b0;
    // Fifth round, phase 1 is RUN cycle 4*3+1+1 = 14.
    for (int i = 1; i < 14; i++) tick();
    o = obs3();
    total++;
    if (o !== exp_q[13] || round_cst !== 8'hB4 || phase !== 2'd1) begin
      bad++;
      $display("FAIL abort_pre got=%h want=%h", o, exp_q[13]);
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs3() !== 16'h0) begin
        bad++;
        $display("FAIL abort_idle cycle=%0d got=%h want=0000", i, obs3());
      end
      tick();
    end
    test_run("after_abort_nr8", 8, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    int pulses = 0;
    start1 = 1'b1; nr1 = 4'd1;
    tick();
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       want = {1'b1, 1'b0, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b1, 2'd0};
        1:       want = {1'b1, 1'b1, 14'h0};
        default: want = 16'h0;
      endcase
      total++;
      if (obs1() !== want) begin
        bad++;
        $display("FAIL back_to_back cycle=%0d got=%h want=%h", i, obs1(), want);
      end
      if (done1) pulses++;
      tick();
    end
    start1 = 1'b0;
    total++;
    if (pulses != 4) begin
      bad++;
      $display("FAIL back_to_back_pulses got=%0d want=4", pulses);
    end
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_full_run();
    test_nr_cases();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
